// File: rtl/trace_pkg.sv
// Shared definitions for the debug writeback trace checker.
//   - fail_code_t : failure cause reported on fail_code
//   - state_t     : checker run state (RUN / FAIL / DONE)
//   - gold_t      : one golden trace entry {pc, wnum, wdata}, 69 bits
//   - byte_mask() : expands the per-byte write enables into a 32-bit mask
package trace_pkg;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_PC        = 3'd1,
    FC_WNUM      = 3'd2,
    FC_WDATA     = 3'd3,
    FC_UNDERFLOW = 3'd4,
    FC_TIMEOUT   = 3'd5
  } fail_code_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FAIL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int GOLD_W = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] we);
    byte_mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding golden trace entries.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i : write request and data; accepted when not full or when
//                     a pop happens in the same cycle
//   pop_i           : remove the head entry (ignored when empty)
//   rdata_o         : head entry (valid when !empty_o)
//   full_o, empty_o : occupancy flags
module trace_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a push is only legal alongside a pop; the write lands in the
  // slot the head is leaving, and the head read above still sees old data.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/trace_checker.sv
// Debug writeback trace checker. Compares every register-write event of the
// CPU debug trace against golden entries delivered over valid/ready.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   debug_wb_*           : retiring PC, byte write enables, dest reg, data
//   gold_valid/gold_ready: golden entry handshake; an entry transfers on a
//                          cycle where both are high. gold_valid may be held
//                          without ready; the entry must stay stable until it
//                          transfers. ready only depends on state, FIFO
//                          fullness and whether this cycle pops.
//   gold_pc/wnum/wdata   : golden entry payload
//   done, pass, fail     : run status (sticky until reset)
//   fail_code, fail_pc   : failure cause and the retiring PC at failure
//   fail_exp/got_wdata   : expected / byte-masked observed data (data mismatch)
//   wb_count             : number of successfully checked write events
//   dbg_state            : current checker state
module trace_checker
  import trace_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] END_PC     = 32'h1c000100,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  fail_code,
  output logic [31:0] fail_pc,
  output logic [31:0] fail_exp_wdata,
  output logic [31:0] fail_got_wdata,
  output logic [31:0] wb_count,
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  fail_code_t  fail_code_q, fail_code_d;
  logic [31:0] fail_pc_q, fail_pc_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] got_q, got_d;
  logic [31:0] wb_count_q, wb_count_d;
  logic [31:0] to_cnt_q, to_cnt_d;

  gold_t       gold_in, head, src;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        in_run, ev, have_src, ev_ok;
  logic [31:0] mask;
  fail_code_t  fc;

  assign gold_in.pc    = gold_pc;
  assign gold_in.wnum  = gold_wnum;
  assign gold_in.wdata = gold_wdata;

  trace_fifo #(
    .W     (GOLD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (gold_in),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_run = (state_q == ST_RUN);
  // Writes to r0 are architecturally discarded and never traced.
  assign ev     = in_run & (debug_wb_rf_we != 4'b0) & (debug_wb_rf_wnum != 5'd0);
  // Empty FIFO: the entry on the input port is checked directly (bypass).
  assign have_src = ~fifo_empty | gold_valid;
  assign src      = fifo_empty ? gold_in : head;
  assign mask     = byte_mask(debug_wb_rf_we);

  // Failure detection, in priority order.
  always_comb begin
    fc = FC_NONE;
    if (ev) begin
      if (!have_src)                                   fc = FC_UNDERFLOW;
      else if (src.pc != debug_wb_pc)                  fc = FC_PC;
      else if (src.wnum != debug_wb_rf_wnum)           fc = FC_WNUM;
      else if (((src.wdata ^ debug_wb_rf_wdata) & mask) != 32'b0)
                                                       fc = FC_WDATA;
    end else if (in_run && (TIMEOUT != 0) && (to_cnt_q == TIMEOUT - 1)) begin
      fc = FC_TIMEOUT;
    end
  end

  assign ev_ok      = ev & (fc == FC_NONE);
  assign fifo_pop   = ev_ok & ~fifo_empty;
  assign gold_ready = in_run & (~fifo_full | fifo_pop);
  // A bypassed entry is consumed by this cycle's event and must not be stored.
  assign fifo_push  = gold_valid & gold_ready & ~(ev & fifo_empty);

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    fail_pc_d   = fail_pc_q;
    exp_d       = exp_q;
    got_d       = got_q;
    wb_count_d  = wb_count_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      ST_RUN: begin
        to_cnt_d = ev ? 32'd0 : to_cnt_q + 32'd1;
        if (ev_ok) wb_count_d = wb_count_q + 32'd1;
        if (fc != FC_NONE) begin
          state_d     = ST_FAIL;
          fail_code_d = fc;
          fail_pc_d   = debug_wb_pc;
          if (fc == FC_WDATA) begin
            exp_d = src.wdata;
            got_d = debug_wb_rf_wdata & mask;
          end
        end else if (debug_wb_pc == END_PC) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fail_code_q <= FC_NONE;
      fail_pc_q   <= '0;
      exp_q       <= '0;
      got_q       <= '0;
      wb_count_q  <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      fail_pc_q   <= fail_pc_d;
      exp_q       <= exp_d;
      got_q       <= got_d;
      wb_count_q  <= wb_count_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign done           = (state_q != ST_RUN);
  assign pass           = (state_q == ST_DONE);
  assign fail           = (state_q == ST_FAIL);
  assign fail_code      = fail_code_q;
  assign fail_pc        = fail_pc_q;
  assign fail_exp_wdata = exp_q;
  assign fail_got_wdata = got_q;
  assign wb_count       = wb_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: a default instance plus a TIMEOUT=10
// instance sharing the same stimulus.
module tb_trace_checker;
  import trace_pkg::*;

  localparam logic [31:0] END_PC = 32'h1c000100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [3:0]  we = '0;
  logic [4:0]  wnum = '0;
  logic [31:0] wdata = '0;
  logic        gold_valid = 1'b0;
  logic [31:0] gold_pc = '0;
  logic [4:0]  gold_wnum = '0;
  logic [31:0] gold_wdata = '0;

  logic        d_ready, d_done, d_pass, d_fail;
  logic [2:0]  d_code;
  logic [31:0] d_fpc, d_exp, d_got, d_cnt;
  state_t      d_state;

  logic        t_ready, t_done, t_pass, t_fail;
  logic [2:0]  t_code;
  logic [31:0] t_fpc, t_exp, t_got, t_cnt;
  state_t      t_state;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  trace_checker #(.FIFO_DEPTH(8), .END_PC(END_PC), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(pc), .debug_wb_rf_we(we), .debug_wb_rf_wnum(wnum),
    .debug_wb_rf_wdata(wdata),
    .gold_valid(gold_valid), .gold_ready(d_ready),
    .gold_pc(gold_pc), .gold_wnum(gold_wnum), .gold_wdata(gold_wdata),
    .done(d_done), .pass(d_pass), .fail(d_fail), .fail_code(d_code),
    .fail_pc(d_fpc), .fail_exp_wdata(d_exp), .fail_got_wdata(d_got),
    .wb_count(d_cnt), .dbg_state(d_state)
  );

  trace_checker #(.FIFO_DEPTH(8), .END_PC(END_PC), .TIMEOUT(10)) dut_t (
    .clk(clk), .reset(reset),
    .debug_wb_pc(pc), .debug_wb_rf_we(we), .debug_wb_rf_wnum(wnum),
    .debug_wb_rf_wdata(wdata),
    .gold_valid(gold_valid), .gold_ready(t_ready),
    .gold_pc(gold_pc), .gold_wnum(gold_wnum), .gold_wdata(gold_wdata),
    .done(t_done), .pass(t_pass), .fail(t_fail), .fail_code(t_code),
    .fail_pc(t_fpc), .fail_exp_wdata(t_exp), .fail_got_wdata(t_got),
    .wb_count(t_cnt), .dbg_state(t_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc = '0; we = '0; wnum = '0; wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gold_valid = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_gold(input logic [31:0] p, input logic [4:0] n,
                          input logic [31:0] d);
    gold_pc = p; gold_wnum = n; gold_wdata = d;
  endtask

  task automatic push_gold(input logic [31:0] p, input logic [4:0] n,
                           input logic [31:0] d);
    set_gold(p, n, d);
    gold_valid = 1'b1;
    tick();
    gold_valid = 1'b0;
  endtask

  task automatic wb_event(input logic [31:0] p, input logic [4:0] n,
                          input logic [31:0] d, input logic [3:0] e);
    pc = p; wnum = n; wdata = d; we = e;
    tick();
    idle();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_done"}, 32'(d_done), 32'd0);
    check_val({tag, "_pass"}, 32'(d_pass), 32'd0);
    check_val({tag, "_fail"}, 32'(d_fail), 32'd0);
    check_val({tag, "_code"}, 32'(d_code), 32'd0);
    check_val({tag, "_fpc"},  d_fpc, 32'd0);
    check_val({tag, "_exp"},  d_exp, 32'd0);
    check_val({tag, "_got"},  d_got, 32'd0);
    check_val({tag, "_cnt"},  d_cnt, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    do_reset();
    check_zero("rst");
    check_val("rst_ready", 32'(d_ready), 32'd1);

    // Three matching events, then END_PC.
    push_gold(32'h1c000000, 5'd1, 32'h5);
    push_gold(32'h1c000004, 5'd2, 32'h7);
    push_gold(32'h1c000008, 5'd3, 32'hc);
    wb_event(32'h1c000000, 5'd1, 32'h5, 4'hf);
    check_val("p1_cnt1", d_cnt, 32'd1);
    wb_event(32'h1c000004, 5'd2, 32'h7, 4'hf);
    wb_event(32'h1c000008, 5'd3, 32'hc, 4'hf);
    pc = END_PC;
    tick();
    idle();
    check_val("p1_pass", 32'(d_pass), 32'd1);
    check_val("p1_done", 32'(d_done), 32'd1);
    check_val("p1_fail", 32'(d_fail), 32'd0);
    check_val("p1_cnt",  d_cnt, 32'd3);
    check_val("p1_ready", 32'(d_ready), 32'd0);

    // Data mismatch, then later stimulus ignored.
    do_reset();
    push_gold(32'h1c000004, 5'd2, 32'h7);
    wb_event(32'h1c000004, 5'd2, 32'h8, 4'hf);
    check_val("dm_fail", 32'(d_fail), 32'd1);
    check_val("dm_done", 32'(d_done), 32'd1);
    check_val("dm_code", 32'(d_code), 32'd3);
    check_val("dm_fpc",  d_fpc, 32'h1c000004);
    check_val("dm_exp",  d_exp, 32'h7);
    check_val("dm_got",  d_got, 32'h8);
    check_val("dm_cnt",  d_cnt, 32'd0);
    pc = END_PC;
    tick();
    idle();
    check_val("dm_sticky_pass", 32'(d_pass), 32'd0);
    check_val("dm_sticky_code", 32'(d_code), 32'd3);

    // Byte masking: only enabled bytes compare; got is masked.
    do_reset();
    push_gold(32'h1c000010, 5'd4, 32'h12345678);
    push_gold(32'h1c000014, 5'd5, 32'h00000011);
    wb_event(32'h1c000010, 5'd4, 32'haabbcc78, 4'b0001);
    check_val("bm_ok_fail", 32'(d_fail), 32'd0);
    check_val("bm_ok_cnt",  d_cnt, 32'd1);
    wb_event(32'h1c000014, 5'd5, 32'h0000ff22, 4'b0001);
    check_val("bm_code", 32'(d_code), 32'd3);
    check_val("bm_exp",  d_exp, 32'h11);
    check_val("bm_got",  d_got, 32'h22);

    // Register mismatch.
    do_reset();
    push_gold(32'h1c000000, 5'd2, 32'h1);
    wb_event(32'h1c000000, 5'd3, 32'h1, 4'hf);
    check_val("rn_code", 32'(d_code), 32'd2);
    check_val("rn_exp",  d_exp, 32'd0);

    // PC mismatch.
    do_reset();
    push_gold(32'h1c000010, 5'd1, 32'h1);
    wb_event(32'h1c000014, 5'd1, 32'h1, 4'hf);
    check_val("pc_code", 32'(d_code), 32'd1);
    check_val("pc_fpc",  d_fpc, 32'h1c000014);

    // PC and data wrong: PC wins.
    do_reset();
    push_gold(32'h1c000010, 5'd1, 32'h1);
    wb_event(32'h1c000014, 5'd1, 32'h2, 4'hf);
    check_val("pd_code", 32'(d_code), 32'd1);
    check_val("pd_got",  d_got, 32'd0);

    // Underflow.
    do_reset();
    wb_event(32'h1c000000, 5'd1, 32'h1, 4'hf);
    check_val("uf_code", 32'(d_code), 32'd4);
    check_val("uf_fail", 32'(d_fail), 32'd1);

    // Bypass: entry checked directly and not stored.
    do_reset();
    set_gold(32'h1c000020, 5'd1, 32'h9);
    gold_valid = 1'b1;
    pc = 32'h1c000020; wnum = 5'd1; wdata = 32'h9; we = 4'hf;
    #1;
    check_val("bp_ready", 32'(d_ready), 32'd1);
    tick();
    idle();
    gold_valid = 1'b0;
    check_val("bp_fail", 32'(d_fail), 32'd0);
    check_val("bp_cnt",  d_cnt, 32'd1);
    wb_event(32'h1c000024, 5'd1, 32'h1, 4'hf);
    check_val("bp_nopush_code", 32'(d_code), 32'd4);

    // Timeout on the TIMEOUT=10 instance.
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    check_val("to9_fail", 32'(t_fail), 32'd0);
    tick();
    check_val("to10_code", 32'(t_code), 32'd5);
    check_val("to10_done", 32'(t_done), 32'd1);

    // r0 writes and we=0 cycles do not clear the timeout counter.
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    we = 4'hf; wnum = 5'd0; tick(); tick();
    we = 4'h0; wnum = 5'd5; tick(); tick();
    idle();
    check_val("tn_fail9", 32'(t_fail), 32'd0);
    tick();
    check_val("tn_code", 32'(t_code), 32'd5);

    // A real event clears the timeout counter.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    set_gold(32'h1c000030, 5'd6, 32'h3);
    gold_valid = 1'b1;
    wb_event(32'h1c000030, 5'd6, 32'h3, 4'hf);
    gold_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check_val("tc_fail", 32'(t_fail), 32'd0);
    check_val("tc_cnt",  t_cnt, 32'd1);
    tick();
    check_val("tc_code", 32'(t_code), 32'd5);

    // Full FIFO: simultaneous pop and push keeps occupancy at 8.
    do_reset();
    for (int i = 0; i < 8; i++)
      push_gold(32'(32'h1c000040 + 4 * i), 5'(i + 1), 32'(32'h10 + i));
    set_gold(32'h1c000060, 5'd9, 32'h18);
    gold_valid = 1'b1;
    #1;
    check_val("ff_full_ready", 32'(d_ready), 32'd0);
    pc = 32'h1c000040; wnum = 5'd1; wdata = 32'h10; we = 4'hf;
    #1;
    check_val("ff_pop_ready", 32'(d_ready), 32'd1);
    tick();
    idle();
    check_val("ff_fail", 32'(d_fail), 32'd0);
    check_val("ff_cnt1", d_cnt, 32'd1);
    check_val("ff_still_full", 32'(d_ready), 32'd0);
    gold_valid = 1'b0;
    for (int i = 1; i <= 8; i++)
      wb_event(32'(32'h1c000040 + 4 * i), 5'(i + 1), 32'(32'h10 + i), 4'hf);
    check_val("ff_drain_fail", 32'(d_fail), 32'd0);
    check_val("ff_drain_cnt",  d_cnt, 32'd9);
    wb_event(32'h1c000070, 5'd1, 32'h1, 4'hf);
    check_val("ff_empty_code", 32'(d_code), 32'd4);

    // Reset while in FAIL clears everything on the next edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rf");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Simulation/FPGA-side consumer of the CPU's debug writeback trace (debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata).
- Compares each register-write event against a golden-trace stream supplied over a valid/ready interface and buffered in a small FIFO.
- Reports pass/fail, the first mismatch, a write-event count and a timeout when the core stops retiring.
- Sits beside mycpu_top in the SoC/testbench top and is the receiving end of the debug trace.

Parameters:
- FIFO_DEPTH, 8, golden-entry buffer depth; power of two, >= 2.
- END_PC, 32'h1c000100, observing this debug_wb_pc ends the run.
- TIMEOUT, 1000, cycles with no write event before failing; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- debug_wb_pc  in  32  retiring PC
- debug_wb_rf_we  in  4  per-byte write enables
- debug_wb_rf_wnum  in  5  destination register
- debug_wb_rf_wdata  in  32  write data
- gold_valid  in  1  golden entry available
- gold_ready  out  1  checker accepts a golden entry
- gold_pc  in  32  expected PC
- gold_wnum  in  5  expected register
- gold_wdata  in  32  expected data
- done  out  1  run finished (pass or fail)
- pass  out  1  END_PC reached with no failure
- fail  out  1  failure detected
- fail_code  out  3  failure cause
- fail_pc  out  32  debug_wb_pc at the failure
- fail_exp_wdata  out  32  expected data at a data mismatch
- fail_got_wdata  out  32  byte-masked observed data at a data mismatch
- wb_count  out  32  number of checked write events

Behaviour:
- Reset: clk and reset are synchronous, active-high; reset is sampled on the rising edge of clk. Reset empties the FIFO and sets the state to RUN. All outputs go to 0: done, pass, fail, fail_code, fail_pc, fail_exp/got, wb_count, timeout counter.
- Reset asserted mid-run clears any failure or done status on the next edge.
- Event definition: in RUN, an event occurs in a cycle where debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0. Writes to r0 are ignored.
- Golden source: the FIFO head, or, when the FIFO is empty and gold_valid=1, the input directly (bypass). A bypassed entry is consumed and is not pushed.
- gold_ready = (state==RUN) & (!full | pop). A push and a pop in the same cycle are allowed, including when full.
- Comparison (combinational, registered on the same edge; check priority order):
  - PC: gold_pc != debug_wb_pc -> code 1.
  - Register: gold_wnum != wnum -> code 2.
  - Data: (gold_wdata ^ wdata) & byte mask from rf_we != 0 -> code 3.
- Underflow: an event with the FIFO empty and gold_valid=0 -> code 4.
- Timeout: the counter increments each RUN cycle without an event and clears on every event. Reaching TIMEOUT -> code 5.
- Successful event: pop the entry and increment wb_count (wraps at 2^32).
- End: debug_wb_pc==END_PC in RUN with no failure that cycle -> DONE with pass=1, done=1. A failure in the same cycle takes priority (FAIL). If the END_PC cycle is also a valid event, that event is checked first.
- FAIL: fail=1, done=1, fail_code, fail_pc, fail_exp_wdata and fail_got_wdata latched. Latch the wdata fields only for code 3; otherwise they are 0.
- FAIL and DONE are sticky until reset. gold_ready=0 and no further checks occur.
- Leftover golden entries at END_PC are ignored.
- States: RUN -> FAIL on any failure code; RUN -> DONE on END_PC. No other transitions.

Decomposition:
- Shared package trace_pkg:
  - fail codes FC_NONE=0, FC_PC=1, FC_WNUM=2, FC_WDATA=3, FC_UNDERFLOW=4, FC_TIMEOUT=5.
  - state encoding RUN/FAIL/DONE.
  - golden-entry width 69 (pc, wnum, wdata).
- One sub-module, trace_fifo: synchronous FIFO with full/empty flags and simultaneous push/pop, parameterised on width and depth.

Test Plan:
- Prefill 3 golden entries (1c000000/r1/5, 1c000004/r2/7, 1c000008/r3/c); drive 3 matching events, then pc=END_PC -> pass=1, done=1, wb_count=3.
- Event pc=1c000004, r2, wdata=8 against golden 7 -> next cycle fail=1, fail_code=3, fail_pc=1c000004, exp=7, got=8; later stimulus is ignored.
- Golden r2 with event r3; separately, golden pc 1c000010 with event pc 1c000014 -> codes 2 and 1 respectively. An event that is wrong in pc and data both reports code 1.
- FIFO empty, gold_valid=0, event on r1 -> code 4. Repeat with gold_valid=1 and a matching entry -> bypass, gold_ready=1, no fail, wb_count=1.
- TIMEOUT=10, no events for 10 cycles -> fail_code=5. An rf_we=0 or wnum=0 cycle does not clear the counter.
- Fill the FIFO to 8 (gold_ready=0); an event plus gold_valid in the same cycle -> pop and push, gold_ready=1, occupancy stays 8. Assert reset while in FAIL -> all outputs 0 on the next cycle.
